// File: rtl/i2c_reg_seq.sv
// rtl/i2c_reg_seq.sv - register-access sequencer driving i2c_master commands
module i2c_reg_seq #(
   parameter int TO_CYC = 65535,
   parameter int C_SZ   = 6,
   parameter int S_SZ   = 2,
   parameter int C_STRT = 0,
   parameter int C_STOP = 1,
   parameter int C_READ = 2,
   parameter int C_WRTE = 3,
   parameter int C_NACK = 4,
   parameter int C_CLRS = 5,
   parameter int SB_BSY = 0,
   parameter int SB_ERR = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic            rnw,
   input  logic [6:0]      dev_adr,
   input  logic [7:0]      reg_adr,
   input  logic [7:0]      wdat,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [7:0]      rdat,
   output logic [C_SZ-1:0] m_cmd,
   output logic [7:0]      m_dat,
   output logic            m_ws,
   input  logic [S_SZ-1:0] m_stat,
   input  logic [7:0]      m_rdat
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ISSUE  = 3'd1;
   localparam logic [2:0] ST_W_BSY  = 3'd2;
   localparam logic [2:0] ST_W_IDLE = 3'd3;
   localparam logic [2:0] ST_CLRS   = 3'd4;
   localparam logic [2:0] ST_FIN    = 3'd5;

   localparam logic [C_SZ-1:0] ONE    = {{(C_SZ-1){1'b0}}, 1'b1};
   localparam logic [C_SZ-1:0] M_STRT = ONE << C_STRT;
   localparam logic [C_SZ-1:0] M_STOP = ONE << C_STOP;
   localparam logic [C_SZ-1:0] M_READ = ONE << C_READ;
   localparam logic [C_SZ-1:0] M_WRTE = ONE << C_WRTE;
   localparam logic [C_SZ-1:0] M_NACK = ONE << C_NACK;
   localparam logic [C_SZ-1:0] M_CLRS = ONE << C_CLRS;

   localparam int           TW      = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
   localparam logic [TW-1:0] TMO_MAX = TW'(TO_CYC - 1);

   logic [2:0]      state_q, state_d;
   logic [1:0]      step_q, step_d;
   logic            rnw_q, rnw_d;
   logic [6:0]      dev_q, dev_d;
   logic [7:0]      reg_q, reg_d;
   logic [7:0]      wdat_q, wdat_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [7:0]      rdat_q, rdat_d;
   logic [C_SZ-1:0] m_cmd_q, m_cmd_d;
   logic [7:0]      m_dat_q, m_dat_d;
   logic            m_ws_q, m_ws_d;
   logic [TW-1:0]   tmo_q, tmo_d;

   logic            st_bsy, st_err, last_step;

   // Command word for step s; the read path re-addresses the device with R/W=1.
   function automatic logic [C_SZ+7:0] step_word(input logic [1:0] s, input logic r,
                                                 input logic [6:0] d, input logic [7:0] ra,
                                                 input logic [7:0] wd);
      logic [C_SZ-1:0] c;
      logic [7:0]      b;
      c = '0;
      b = 8'h00;
      case (s)
         2'd0: begin c = M_STRT | M_WRTE; b = {d, 1'b0}; end
         2'd1: begin c = M_WRTE;          b = ra;         end
         2'd2: begin
            if (r) begin c = M_STRT | M_WRTE; b = {d, 1'b1}; end
            else   begin c = M_WRTE | M_STOP; b = wd;        end
         end
         default: begin c = M_READ | M_NACK | M_STOP; b = 8'h00; end
      endcase
      return {c, b};
   endfunction

   assign st_bsy    = m_stat[SB_BSY];
   assign st_err    = m_stat[SB_ERR];
   assign last_step = rnw_q ? (step_q == 2'd3) : (step_q == 2'd2);

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      rnw_d   = rnw_q;
      dev_d   = dev_q;
      reg_d   = reg_q;
      wdat_d  = wdat_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      rdat_d  = rdat_q;
      m_cmd_d = m_cmd_q;
      m_dat_d = m_dat_q;
      m_ws_d  = 1'b0;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               rnw_d   = rnw;
               dev_d   = dev_adr;
               reg_d   = reg_adr;
               wdat_d  = wdat;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               step_d  = 2'd0;
               {m_cmd_d, m_dat_d} = step_word(2'd0, rnw, dev_adr, reg_adr, wdat);
               m_ws_d  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            tmo_d   = '0;
            state_d = ST_W_BSY;
         end
         ST_W_BSY, ST_W_IDLE: begin
            tmo_d = tmo_q + 1'b1;
            if (state_q == ST_W_BSY && st_err) begin
               state_d = ST_CLRS;
            end else if (state_q == ST_W_BSY && st_bsy) begin
               state_d = ST_W_IDLE;
            end else if (state_q == ST_W_IDLE && !st_bsy) begin
               if (st_err) begin
                  state_d = ST_CLRS;
               end else if (last_step) begin
                  if (rnw_q) rdat_d = m_rdat;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_FIN;
               end else begin
                  step_d  = step_q + 2'd1;
                  {m_cmd_d, m_dat_d} = step_word(step_q + 2'd1, rnw_q, dev_q, reg_q, wdat_q);
                  m_ws_d  = 1'b1;
                  state_d = ST_ISSUE;
               end
            end else if (tmo_q == TMO_MAX) begin
               state_d = ST_CLRS;
            end
            // Entering CLRS strobes the clear command; m_dat keeps its last value.
            if (state_d == ST_CLRS) begin
               m_cmd_d = M_CLRS;
               m_ws_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         ST_CLRS: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FIN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= 2'd0;
         rnw_q   <= 1'b0;
         dev_q   <= 7'h00;
         reg_q   <= 8'h00;
         wdat_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdat_q  <= 8'h00;
         m_cmd_q <= '0;
         m_dat_q <= 8'h00;
         m_ws_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rnw_q   <= rnw_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         wdat_q  <= wdat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
         m_cmd_q <= m_cmd_d;
         m_dat_q <= m_dat_d;
         m_ws_q  <= m_ws_d;
         tmo_q   <= tmo_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign rdat  = rdat_q;
   assign m_cmd = m_cmd_q;
   assign m_dat = m_dat_q;
   assign m_ws  = m_ws_q;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// tb/tb_i2c_reg_seq.sv - directed bench for i2c_reg_seq with a behavioural master
module tb_i2c_reg_seq;

   localparam int TO_CYC = 200;
   localparam logic [5:0] K_SW  = 6'h09;   // STRT|WRTE
   localparam logic [5:0] K_W   = 6'h08;   // WRTE
   localparam logic [5:0] K_WS  = 6'h0A;   // WRTE|STOP
   localparam logic [5:0] K_RNS = 6'h16;   // READ|NACK|STOP
   localparam logic [5:0] K_CL  = 6'h20;   // CLRS

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       rnw = 1'b0;
   logic [6:0] dev_adr = 7'h00;
   logic [7:0] reg_adr = 8'h00;
   logic [7:0] wdat = 8'h00;
   logic       busy, done, err, m_ws;
   logic [7:0] rdat, m_dat;
   logic [5:0] m_cmd;
   logic [1:0] m_stat;
   logic [7:0] m_rdat = 8'h55;

   i2c_reg_seq #(.TO_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst), .req(req), .rnw(rnw), .dev_adr(dev_adr),
      .reg_adr(reg_adr), .wdat(wdat), .busy(busy), .done(done), .err(err),
      .rdat(rdat), .m_cmd(m_cmd), .m_dat(m_dat), .m_ws(m_ws),
      .m_stat(m_stat), .m_rdat(m_rdat)
   );

   always #5 clk = ~clk;

   // Master model: BSY rises 2 cycles after ws, falls 4 cycles later; a START to a
   // device other than 7'h3b ends with ERR set until CLRS.
   logic [3:0] cnt;
   logic       bsy, errf, pend, prev_ws, hang, inj_err;
   logic [5:0] log_cmd [128];
   logic [7:0] log_dat [128];
   int         log_n = 0, ws_b2b = 0, ws_bsy = 0, done_cnt = 0;

   assign m_stat = {errf | inj_err, bsy};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 0; bsy <= 0; errf <= 0; pend <= 0; prev_ws <= 0;
      end else begin
         prev_ws <= m_ws;
         if (m_ws) begin
            if (prev_ws) ws_b2b <= ws_b2b + 1;
            if (bsy && m_cmd != K_CL) ws_bsy <= ws_bsy + 1;
            log_cmd[log_n] <= m_cmd;
            log_dat[log_n] <= m_dat;
            log_n <= log_n + 1;
            if (m_cmd == K_CL) errf <= 1'b0;
            else begin
               cnt  <= 4'd6;
               pend <= m_cmd[0] && (m_dat[7:1] != 7'h3b);
            end
         end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 4'd5) bsy <= 1'b1;
            if (cnt == 4'd1 && !hang) begin
               bsy <= 1'b0;
               if (pend) errf <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   int  base, dbase;
   logic got_err;
   logic [7:0] got_rdat;

   task automatic start(input logic r, input logic [6:0] d, input logic [7:0] ra,
                        input logic [7:0] wd, input int hold);
      @(negedge clk);
      base = log_n; dbase = done_cnt;
      rnw = r; dev_adr = d; reg_adr = ra; wdat = wd; req = 1'b1;
      repeat (hold) @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (done) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      chk({tag, "_done"}, seen, 1'b1);
      got_err = err; got_rdat = rdat;
      chk({tag, "_busy_fin"}, busy, 1'b0);
      @(negedge clk);
      chk({tag, "_done_pulses"}, done_cnt - dbase, 1);
   endtask

   task automatic chk_cmd(input string tag, input int k, input logic [5:0] c,
                          input logic [7:0] d);
      chk({tag, "_cmd"}, log_cmd[base + k], c);
      chk({tag, "_dat"}, log_dat[base + k], d);
   endtask

   initial begin
      hang = 1'b0; inj_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rdat", rdat, 8'h00);
      chk("rst_cmd", m_cmd, 6'h00);
      chk("rst_dat", m_dat, 8'h00);
      chk("rst_ws", m_ws, 0);
      rst = 1'b0;

      start(1'b0, 7'h3b, 8'h10, 8'hA7, 1);
      wait_done("wr");
      chk("wr_nws", log_n - base, 3);
      chk_cmd("wr_s0", 0, K_SW, 8'h76);
      chk_cmd("wr_s1", 1, K_W, 8'h10);
      chk_cmd("wr_s2", 2, K_WS, 8'hA7);
      chk("wr_err", got_err, 0);

      start(1'b1, 7'h3b, 8'h10, 8'h00, 1);
      wait_done("rd");
      chk("rd_nws", log_n - base, 4);
      chk_cmd("rd_s0", 0, K_SW, 8'h76);
      chk_cmd("rd_s1", 1, K_W, 8'h10);
      chk_cmd("rd_s2", 2, K_SW, 8'h77);
      chk("rd_s3_cmd", log_cmd[base + 3], K_RNS);
      chk("rd_err", got_err, 0);
      chk("rd_rdat", got_rdat, 8'h55);

      m_rdat = 8'hC3;
      start(1'b1, 7'h2a, 8'h10, 8'h00, 1);
      wait_done("nak");
      chk("nak_nws", log_n - base, 2);
      chk_cmd("nak_s0", 0, K_SW, 8'h54);
      chk("nak_clrs", log_cmd[base + 1], K_CL);
      chk("nak_err", got_err, 1);
      chk("nak_rdat_held", got_rdat, 8'h55);

      start(1'b1, 7'h3b, 8'h21, 8'h00, 1);
      wait_done("rd2");
      chk("rd2_rdat", got_rdat, 8'hC3);
      chk("rd2_err_clr", got_err, 0);

      start(1'b0, 7'h3b, 8'h44, 8'h5A, 4);
      repeat (5) @(negedge clk);
      req = 1'b1; wdat = 8'hEE; reg_adr = 8'h99;
      @(negedge clk);
      req = 1'b0;
      wait_done("one");
      repeat (30) @(negedge clk);
      chk("one_nws", log_n - base, 3);
      chk_cmd("one_s1", 1, K_W, 8'h44);
      chk_cmd("one_s2", 2, K_WS, 8'h5A);
      chk("one_ndone", done_cnt - dbase, 1);

      hang = 1'b1;
      start(1'b0, 7'h3b, 8'h10, 8'h01, 1);
      wait_done("tmo");
      chk("tmo_err", got_err, 1);
      chk("tmo_nws", log_n - base, 2);
      chk("tmo_clrs", log_cmd[base + 1], K_CL);
      rst = 1'b1; hang = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      start(1'b0, 7'h3b, 8'h10, 8'h02, 1);
      for (int i = 0; i < 200 && (log_n - base) < 2; i++) @(negedge clk);
      chk("mid_in_s1", log_n - base, 2);
      rst = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_ws", m_ws, 0);
      @(negedge clk);
      rst = 1'b0;
      start(1'b0, 7'h3b, 8'h30, 8'h3C, 1);
      wait_done("post");
      chk("post_nws", log_n - base, 3);
      chk_cmd("post_s2", 2, K_WS, 8'h3C);
      chk("post_err", got_err, 0);

      inj_err = 1'b1;
      start(1'b0, 7'h3b, 8'h10, 8'h11, 1);
      wait_done("inj");
      inj_err = 1'b0;
      chk("inj_nws", log_n - base, 2);
      chk_cmd("inj_s0", 0, K_SW, 8'h76);
      chk("inj_clrs", log_cmd[base + 1], K_CL);
      chk("inj_err", got_err, 1);

      chk("ws_back_to_back", ws_b2b, 0);
      chk("ws_while_bsy", ws_bsy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
